// File: rtl/aurora_link_monitor.sv
// Aurora link health monitor: per-lane and core fault counters, FIFO overflow
// onset counters, AXI-Stream beat/byte counters and a registered status summary.
module aurora_link_monitor #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 32,
  parameter int KEEP_W    = 64,
  parameter int EDGE_MODE = 0,
  parameter int SATURATE  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       freeze,
  input  logic [NUM_LANES-1:0]       gt_powergood,
  input  logic [NUM_LANES-1:0]       line_up,
  input  logic                       pll_lock,
  input  logic                       mmcm_not_locked,
  input  logic                       hard_err,
  input  logic                       soft_err,
  input  logic                       channel_up,
  input  logic                       fifo_rx_almost_full,
  input  logic                       fifo_tx_almost_full,
  input  logic                       tx_tvalid,
  input  logic                       tx_tready,
  input  logic                       rx_tvalid,
  input  logic [KEEP_W-1:0]          tx_tkeep,
  input  logic [KEEP_W-1:0]          rx_tkeep,
  output logic [NUM_LANES*CNT_W-1:0] gt_not_ready_count,
  output logic [NUM_LANES*CNT_W-1:0] line_down_count,
  output logic [CNT_W-1:0]           pll_not_locked_count,
  output logic [CNT_W-1:0]           mmcm_not_locked_count,
  output logic [CNT_W-1:0]           hard_err_count,
  output logic [CNT_W-1:0]           soft_err_count,
  output logic [CNT_W-1:0]           channel_down_count,
  output logic [CNT_W-1:0]           fifo_rx_overflow_count,
  output logic [CNT_W-1:0]           fifo_tx_overflow_count,
  output logic [CNT_W-1:0]           tx_count,
  output logic [CNT_W-1:0]           rx_count,
  output logic [63:0]                tx_bytes,
  output logic [63:0]                rx_bytes,
  output logic                       status_ok
);

  localparam int NCORE  = 5;
  localparam int C_PLL  = 0;
  localparam int C_MMCM = 1;
  localparam int C_HARD = 2;
  localparam int C_SOFT = 3;
  localparam int C_CHAN = 4;

  logic [NUM_LANES-1:0] gt_fault;
  logic [NUM_LANES-1:0] line_fault;
  logic [NUM_LANES-1:0] gt_prev;
  logic [NUM_LANES-1:0] line_prev;
  logic [NUM_LANES-1:0] gt_hit;
  logic [NUM_LANES-1:0] line_hit;
  logic [NCORE-1:0]     core_fault;
  logic [NCORE-1:0]     core_prev;
  logic [NCORE-1:0]     core_hit;
  logic                 fifo_rx_prev;
  logic                 fifo_tx_prev;
  logic                 fifo_rx_hit;
  logic                 fifo_tx_hit;
  logic                 tx_fire;
  logic                 status_next;

  logic [CNT_W-1:0] gt_cnt   [NUM_LANES];
  logic [CNT_W-1:0] line_cnt [NUM_LANES];
  logic [CNT_W-1:0] core_cnt [NCORE];
  logic [CNT_W-1:0] fifo_rx_cnt;
  logic [CNT_W-1:0] fifo_tx_cnt;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;
  logic [63:0]      tx_byte_cnt;
  logic [63:0]      rx_byte_cnt;

  // Saturating or wrapping increment depending on SATURATE.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
    logic [CNT_W-1:0] r;
    r = v;
    if (inc) begin
      if (&v) r = (SATURATE != 0) ? v : '0;
      else    r = v + CNT_W'(1);
    end
    return r;
  endfunction

  function automatic logic [63:0] popcount(input logic [KEEP_W-1:0] k);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < KEEP_W; i++) s = s + 64'(k[i]);
    return s;
  endfunction

  assign gt_fault   = ~gt_powergood;
  assign line_fault = ~line_up;
  assign core_fault = {~channel_up, soft_err, hard_err, mmcm_not_locked, ~pll_lock};

  assign gt_hit   = (EDGE_MODE != 0) ? (gt_fault & ~gt_prev)     : gt_fault;
  assign line_hit = (EDGE_MODE != 0) ? (line_fault & ~line_prev) : line_fault;
  assign core_hit = (EDGE_MODE != 0) ? (core_fault & ~core_prev) : core_fault;

  assign fifo_rx_hit = fifo_rx_almost_full & ~fifo_rx_prev;
  assign fifo_tx_hit = fifo_tx_almost_full & ~fifo_tx_prev;
  assign tx_fire     = tx_tvalid & tx_tready;

  assign status_next = (&gt_powergood) & (&line_up) & pll_lock & ~mmcm_not_locked
                       & ~hard_err & channel_up;

  // Previous-value registers follow the live conditions through reset, clear
  // and freeze, so a fault already present is never seen as a fresh onset.
  always_ff @(posedge clk) begin
    gt_prev      <= gt_fault;
    line_prev    <= line_fault;
    core_prev    <= core_fault;
    fifo_rx_prev <= fifo_rx_almost_full;
    fifo_tx_prev <= fifo_tx_almost_full;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        gt_cnt[i]   <= '0;
        line_cnt[i] <= '0;
      end
      for (int j = 0; j < NCORE; j++) core_cnt[j] <= '0;
      fifo_rx_cnt <= '0;
      fifo_tx_cnt <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      tx_byte_cnt <= '0;
      rx_byte_cnt <= '0;
    end else if (!freeze) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        gt_cnt[i]   <= bump(gt_cnt[i], gt_hit[i]);
        line_cnt[i] <= bump(line_cnt[i], line_hit[i]);
      end
      for (int j = 0; j < NCORE; j++) core_cnt[j] <= bump(core_cnt[j], core_hit[j]);
      fifo_rx_cnt <= bump(fifo_rx_cnt, fifo_rx_hit);
      fifo_tx_cnt <= bump(fifo_tx_cnt, fifo_tx_hit);
      tx_cnt      <= bump(tx_cnt, tx_fire);
      rx_cnt      <= bump(rx_cnt, rx_tvalid);
      if (tx_fire)   tx_byte_cnt <= tx_byte_cnt + popcount(tx_tkeep);
      if (rx_tvalid) rx_byte_cnt <= rx_byte_cnt + popcount(rx_tkeep);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) status_ok <= 1'b0;
    else     status_ok <= status_next;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign gt_not_ready_count[g*CNT_W +: CNT_W] = gt_cnt[g];
    assign line_down_count[g*CNT_W +: CNT_W]    = line_cnt[g];
  end

  assign pll_not_locked_count   = core_cnt[C_PLL];
  assign mmcm_not_locked_count  = core_cnt[C_MMCM];
  assign hard_err_count         = core_cnt[C_HARD];
  assign soft_err_count         = core_cnt[C_SOFT];
  assign channel_down_count     = core_cnt[C_CHAN];
  assign fifo_rx_overflow_count = fifo_rx_cnt;
  assign fifo_tx_overflow_count = fifo_tx_cnt;
  assign tx_count               = tx_cnt;
  assign rx_count               = rx_cnt;
  assign tx_bytes               = tx_byte_cnt;
  assign rx_bytes               = rx_byte_cnt;

endmodule
